// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS-subset controller driving the shared ALU datapath
// One instruction every 3-5 states; outputs are decoded from the state register.
module mc_ctrl_fsm #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_wr,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e     state_q, state_d;
  logic       rdy;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       bad_op;

  assign rdy   = USE_MEM_READY ? mem_ready : 1'b1;
  assign state = state_q;

  always_comb begin
    funct_alu = 3'b000;
    funct_ok  = 1'b1;
    case (funct)
      6'b100000: funct_alu = 3'b000;
      6'b100010: funct_alu = 3'b001;
      6'b100100: funct_alu = 3'b011;
      6'b100111: funct_alu = 3'b010;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    alu_srcA   = 1'b0;
    alu_srcB   = 2'b00;
    alu_ctrl   = 3'b000;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    illegal_op = 1'b0;
    bad_op     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd   = 1'b1;
        alu_srcB = 2'b01;
        if (rdy) begin
          ir_wr   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // branch target is precomputed into ALUOut while the opcode is decoded
        alu_srcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           if (funct_ok) state_d = S_EXEC; else bad_op = 1'b1;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        bad_op = 1'b1;
        endcase
        if (bad_op) begin
          illegal_op = 1'b1;
          state_d    = TRAP_ILLEGAL ? S_HALT : S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
        state_d  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_srcA = 1'b1;
        alu_ctrl = funct_alu;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_srcA = 1'b1;
        alu_ctrl = 3'b001;
        pc_src   = 2'b01;
        pc_en    = (opcode == OP_BNE) ? ~zero : zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // strobes and selects drop the moment reset asserts, not at the next edge
    if (!rst_n) begin
      alu_srcA   = 1'b0;
      alu_srcB   = 2'b00;
      alu_ctrl   = 3'b000;
      pc_src     = 2'b00;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_wr      = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_wr     = 1'b0;
      illegal_op = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
  typedef struct packed {
    logic       sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] ps;
    logic       pe;
    logic       io;
    logic       rd;
    logic       wr;
    logic       ir;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       ill;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       alu_srcA, pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr, illegal_op;
  logic [1:0] alu_srcB, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] st;
  logic       t_srcA, t_pc_en, t_iord, t_mem_rd, t_mem_wr, t_ir_wr, t_reg_dst, t_m2r, t_reg_wr, t_ill;
  logic [1:0] t_srcB, t_pc_src;
  logic [2:0] t_alu;
  logic [3:0] t_st;

  int n_cmp = 0;
  int n_bad = 0;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .pc_en(pc_en),
    .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_wr(ir_wr), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .illegal_op(illegal_op), .state(st)
  );

  mc_ctrl_fsm #(.USE_MEM_READY(1'b1), .TRAP_ILLEGAL(1'b1)) dut_t (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_srcA(t_srcA), .alu_srcB(t_srcB), .alu_ctrl(t_alu), .pc_src(t_pc_src), .pc_en(t_pc_en),
    .iord(t_iord), .mem_rd(t_mem_rd), .mem_wr(t_mem_wr), .ir_wr(t_ir_wr), .reg_dst(t_reg_dst),
    .mem_to_reg(t_m2r), .reg_wr(t_reg_wr), .illegal_op(t_ill), .state(t_st)
  );

  always #5 clk = ~clk;

  vec_t obs, t_obs;
  assign obs = {alu_srcA, alu_srcB, alu_ctrl, pc_src, pc_en, iord, mem_rd, mem_wr, ir_wr,
                reg_dst, mem_to_reg, reg_wr, illegal_op};
  assign t_obs = {t_srcA, t_srcB, t_alu, t_pc_src, t_pc_en, t_iord, t_mem_rd, t_mem_wr, t_ir_wr,
                  t_reg_dst, t_m2r, t_reg_wr, t_ill};

  task automatic chk(input string tag, input vec_t o, input vec_t e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] o, input logic [3:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Entered and left at a falling edge: drive, settle, compare, move to the next falling edge.
  task automatic cyc(input string tag, input logic rdy, input logic z, input vec_t e);
    mem_ready = rdy;
    zero      = z;
    #1;
    chk(tag, obs, e);
    @(negedge clk);
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b000;
      6'h22:   return 3'b001;
      6'h24:   return 3'b011;
      6'h27:   return 3'b010;
      6'h2a:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] f);
    if (op == 6'h00) return f inside {6'h20, 6'h22, 6'h24, 6'h27, 6'h2a};
    return op inside {6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  // Reference: expected per-cycle control pattern for one instruction, from the ISA rules.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] f,
                           input int fw, input int mw, input logic z);
    vec_t e;
    opcode = op;
    funct  = f;
    e = '0; e.rd = 1'b1; e.sb = 2'b01;
    for (int i = 0; i < fw; i++) cyc({tag, ".fetch_wait"}, 1'b0, rbit(), e);
    e.ir = 1'b1; e.pe = 1'b1;
    cyc({tag, ".fetch"}, 1'b1, rbit(), e);
    e = '0; e.sb = 2'b11; e.ill = !legal(op, f);
    cyc({tag, ".decode"}, rbit(), rbit(), e);
    if (!legal(op, f)) return;
    case (op)
      6'h00: begin
        e = '0; e.sa = 1'b1; e.alu = alu_of(f);
        cyc({tag, ".exec"}, rbit(), rbit(), e);
        e = '0; e.rdst = 1'b1; e.rw = 1'b1;
        cyc({tag, ".aluwb"}, rbit(), rbit(), e);
      end
      6'h23, 6'h2b: begin
        e = '0; e.sa = 1'b1; e.sb = 2'b10;
        cyc({tag, ".memadr"}, rbit(), rbit(), e);
        e = '0; e.io = 1'b1;
        if (op == 6'h23) e.rd = 1'b1; else e.wr = 1'b1;
        for (int i = 0; i < mw; i++) cyc({tag, ".mem_wait"}, 1'b0, rbit(), e);
        cyc({tag, ".mem_done"}, 1'b1, rbit(), e);
        if (op == 6'h23) begin
          e = '0; e.m2r = 1'b1; e.rw = 1'b1;
          cyc({tag, ".memwb"}, rbit(), rbit(), e);
        end
      end
      6'h08: begin
        e = '0; e.sa = 1'b1; e.sb = 2'b10;
        cyc({tag, ".addiex"}, rbit(), rbit(), e);
        e = '0; e.rw = 1'b1;
        cyc({tag, ".addiwb"}, rbit(), rbit(), e);
      end
      6'h04, 6'h05: begin
        e = '0; e.sa = 1'b1; e.alu = 3'b001; e.ps = 2'b01;
        e.pe = (op == 6'h04) ? z : !z;
        cyc({tag, ".branch"}, rbit(), z, e);
      end
      default: begin
        e = '0; e.ps = 2'b10; e.pe = 1'b1;
        cyc({tag, ".jump"}, rbit(), rbit(), e);
      end
    endcase
  endtask

  initial begin
    logic [5:0] fl [5];
    logic [5:0] ol [6];
    logic [5:0] op, f;
    logic [3:0] st_reset, t_halt;
    vec_t e;
    fl = '{6'h20, 6'h22, 6'h24, 6'h27, 6'h2a};
    ol = '{6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02};
    rst_n = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", obs, '0);
    st_reset = st;
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("add",     6'h00, 6'h20, 0, 0, 1'b0);
    run_instr("lw_wait", 6'h23, 6'h00, 0, 3, 1'b0);
    run_instr("beq_z1",  6'h04, 6'h11, 0, 0, 1'b1);
    run_instr("beq_z0",  6'h04, 6'h11, 0, 0, 1'b0);
    run_instr("bne_z1",  6'h05, 6'h00, 0, 0, 1'b1);
    run_instr("bne_z0",  6'h05, 6'h00, 0, 0, 1'b0);
    run_instr("j",       6'h02, 6'h3f, 0, 0, 1'b0);
    run_instr("slt",     6'h00, 6'h2a, 0, 0, 1'b0);
    run_instr("ill_op",  6'h3f, 6'h20, 0, 0, 1'b0);
    run_instr("ill_fn",  6'h00, 6'h21, 0, 0, 1'b0);
    run_instr("sw_wait", 6'h2b, 6'h00, 2, 2, 1'b0);
    run_instr("addi",    6'h08, 6'h00, 1, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0, 1: begin op = 6'h00; f = fl[$urandom_range(0, 4)]; end
        2:    begin op = 6'h00; f = 6'($urandom); end
        3:    begin op = 6'($urandom); f = 6'($urandom); end
        default: begin op = ol[$urandom_range(0, 5)]; f = 6'($urandom); end
      endcase
      run_instr("rand", op, f, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
    end

    // reset asserted while a store is waiting on memory
    opcode = 6'h2b; funct = 6'h00;
    e = '0; e.rd = 1'b1; e.sb = 2'b01; e.ir = 1'b1; e.pe = 1'b1;
    cyc("rstw.fetch", 1'b1, 1'b0, e);
    e = '0; e.sb = 2'b11;
    cyc("rstw.decode", 1'b1, 1'b0, e);
    e = '0; e.sa = 1'b1; e.sb = 2'b10;
    cyc("rstw.memadr", 1'b1, 1'b0, e);
    e = '0; e.io = 1'b1; e.wr = 1'b1;
    mem_ready = 1'b0;
    #1 chk("rstw.memwr", obs, e);
    #1 rst_n = 1'b0;
    #1 chk("rstw.async_drop", obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk4("rstw.state_fetch", st, st_reset);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("post_rst", 6'h00, 6'h24, 0, 0, 1'b0);

    // sticky halt on an illegal opcode in the trapping variant
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 6'h3f; mem_ready = 1'b1;
    #1;
    e = '0; e.rd = 1'b1; e.sb = 2'b01; e.ir = 1'b1; e.pe = 1'b1;
    chk("trap.fetch", t_obs, e);
    @(negedge clk);
    #1;
    e = '0; e.sb = 2'b11; e.ill = 1'b1;
    chk("trap.decode", t_obs, e);
    @(negedge clk);
    #1;
    t_halt = t_st;
    for (int i = 0; i < 100; i++) begin
      mem_ready = rbit();
      zero = rbit();
      opcode = ol[$urandom_range(0, 5)];
      #1;
      chk("trap.halt_outputs", t_obs, '0);
      chk4("trap.halt_state", t_st, t_halt);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
